// File: rtl/fifo_stream_ctrl_if.sv
// rtl/fifo_stream_ctrl_if.sv - push and pop valid/ready streams of fifo_stream_ctrl
interface fifo_stream_ctrl_if #(
  parameter int DATA_WIDTH = 384
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/fifo_stream_ctrl.sv
// rtl/fifo_stream_ctrl.sv - FIFO pointer/count control for an async-read RAM
// Optional sticky ovf/udf flags with `define FIFO_STREAM_ERR_EN.
module fifo_stream_ctrl #(
  parameter int DATA_WIDTH = 384,
  parameter int ADDR_WIDTH = 3,
  parameter int AFULL_LVL  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  fifo_stream_ctrl_if.slave     s,
  output logic                  ram_w_en,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  input  logic [DATA_WIDTH-1:0] ram_r_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
`ifdef FIFO_STREAM_ERR_EN
  output logic                  ovf,
  output logic                  udf,
`endif
  output logic                  afull
);

  localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH+1)'(AFULL_LVL);

  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] rptr;
  logic                push;
  logic                pop;

  // Status comes only from registered pointers/count, never from wr_valid/rd_ready.
  assign full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                 (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
  assign empty = (wptr == rptr);
  assign afull = (count >= AFULL_CNT);

  assign s.wr_ready = ~full;
  assign s.rd_valid = ~empty;
  assign s.rd_data  = ram_r_data;

  assign push = s.wr_valid & ~full;
  assign pop  = s.rd_ready & ~empty;

  assign ram_w_en   = push;
  assign ram_w_addr = wptr[ADDR_WIDTH-1:0];
  assign ram_r_addr = rptr[ADDR_WIDTH-1:0];
  assign ram_w_data = s.wr_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_STREAM_ERR_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (s.wr_valid & full)  ovf <= 1'b1;
      if (s.rd_ready & empty) udf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_ctrl.sv
// tb/tb_fifo_stream_ctrl.sv - scoreboard bench for fifo_stream_ctrl with a behavioural RAM
module tb_fifo_stream_ctrl;

  localparam int DW    = 384;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int AFL   = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          ram_w_en;
  logic [AW-1:0] ram_w_addr;
  logic [AW-1:0] ram_r_addr;
  logic [DW-1:0] ram_w_data;
  logic [DW-1:0] ram_r_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          afull;
`ifdef FIFO_STREAM_ERR_EN
  logic          ovf;
  logic          udf;
  logic          ovf_m = 1'b0;
  logic          udf_m = 1'b0;
`endif

  fifo_stream_ctrl_if #(.DATA_WIDTH(DW)) s ();

  fifo_stream_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LVL(AFL)) dut (
    .clk        (clk),
    .reset      (reset),
    .s          (s),
    .ram_w_en   (ram_w_en),
    .ram_w_addr (ram_w_addr),
    .ram_r_addr (ram_r_addr),
    .ram_w_data (ram_w_data),
    .ram_r_data (ram_r_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
`ifdef FIFO_STREAM_ERR_EN
    .ovf        (ovf),
    .udf        (udf),
`endif
    .afull      (afull)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
  assign ram_r_data = mem[ram_r_addr];

  logic [DW-1:0] q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] mk(input logic [7:0] v);
    return {48{v}};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare against the queue model, then advance one clock and update the model.
  task automatic cycle();
    int   n;
    logic push_e;
    logic pop_e;
    #1;
    n      = q.size();
    push_e = s.wr_valid && (n < DEPTH);
    pop_e  = s.rd_ready && (n > 0);
    check("count",    DW'(count),      DW'(n));
    check("empty",    DW'(empty),      DW'(n == 0));
    check("full",     DW'(full),       DW'(n == DEPTH));
    check("afull",    DW'(afull),      DW'(n >= AFL));
    check("wr_ready", DW'(s.wr_ready), DW'(n < DEPTH));
    check("rd_valid", DW'(s.rd_valid), DW'(n > 0));
    check("ram_w_en", DW'(ram_w_en),   DW'(push_e && reset));
    if (n > 0) check("rd_data", s.rd_data, q[0]);
`ifdef FIFO_STREAM_ERR_EN
    check("ovf", DW'(ovf), DW'(ovf_m));
    check("udf", DW'(udf), DW'(udf_m));
`endif
    @(posedge clk);
    if (!reset) begin
      q.delete();
`ifdef FIFO_STREAM_ERR_EN
      ovf_m = 1'b0;
      udf_m = 1'b0;
`endif
    end else begin
`ifdef FIFO_STREAM_ERR_EN
      if (s.wr_valid && n == DEPTH) ovf_m = 1'b1;
      if (s.rd_ready && n == 0)     udf_m = 1'b1;
`endif
      if (pop_e)  void'(q.pop_front());
      if (push_e) q.push_back(s.wr_data);
    end
    #1;
  endtask

  task automatic drive(input logic wv, input logic [7:0] d, input logic rr);
    s.wr_valid = wv;
    s.wr_data  = mk(d);
    s.rd_ready = rr;
    cycle();
  endtask

  initial begin
    reset      = 1'b0;
    s.wr_valid = 1'b0;
    s.wr_data  = '0;
    s.rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0);

    // Fill to full, then one overflow attempt.
    for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), 1'b0);
    drive(1'b1, 8'h09, 1'b0);
    drive(1'b0, 8'h00, 1'b0);

    // Drain in order, then one underflow attempt.
    for (int i = 0; i < 8; i++) drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);

    // Steady push/pop at count 3 across the address wrap.
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, 8'(8'h30 + i), 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);

    // Full with simultaneous push and pop: only the pop happens.
    for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h60 + i), 1'b0);
    drive(1'b1, 8'hEE, 1'b1);
    drive(1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);

    // Reset mid-stream at count 5, then a fresh push falls through.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h70 + i), 1'b0);
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("rd_data_55", s.rd_data, mk(8'h55));
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);

    check("scoreboard_empty", DW'(q.size()), DW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream_ctrl.md
Name: fifo_stream_ctrl

Overview:
- Control and read-side logic for the team's simple dual-port FIFO RAM (default 8 x 384 bit, asynchronous read, synchronous write).
- Owns the write and read pointers and drives the RAM's w_en, w_addr and r_addr.
- Accepts a valid/ready push stream and presents the RAM contents as a valid/ready pop stream.
- Sits between a producer pipeline stage and its consumer, with the RAM instantiated alongside it.

Parameters:
- DATA_WIDTH, 384, payload width; must match the RAM.
- ADDR_WIDTH, 3, RAM address width; depth = 2**ADDR_WIDTH.
- AFULL_LVL, 6, occupancy at or above which afull asserts; legal range 1..2**ADDR_WIDTH.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- wr_valid  in  1  producer has a word on wr_data.
- wr_ready  out  1  FIFO can accept a word; asserted when not full.
- wr_data  in  DATA_WIDTH  push payload.
- rd_valid  out  1  rd_data holds the oldest word; asserted when not empty.
- rd_ready  in  1  consumer accepts rd_data this cycle.
- rd_data  out  DATA_WIDTH  pop payload, driven from ram_r_data.
- ram_w_en  out  1  RAM write enable.
- ram_w_addr  out  ADDR_WIDTH  RAM write address.
- ram_r_addr  out  ADDR_WIDTH  RAM read address.
- ram_w_data  out  DATA_WIDTH  RAM write data, equal to wr_data.
- ram_r_data  in  DATA_WIDTH  RAM asynchronous read data.
- count  out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
- full  out  1  count == 2**ADDR_WIDTH.
- empty  out  1  count == 0.
- afull  out  1  count >= AFULL_LVL.

Behaviour:
- Pointers:
  - wptr and rptr are ADDR_WIDTH+1 bits wide.
  - The RAM addresses are the low ADDR_WIDTH bits of each pointer.
  - The MSB is a wrap bit.
  - full when the pointer MSBs differ and the low bits are equal.
  - empty when wptr == rptr.
- Reset (reset == 0 at a clock edge):
  - wptr = 0, rptr = 0, count = 0.
  - Outputs after reset: empty = 1, full = 0, afull = 0, wr_ready = 1, rd_valid = 0, ram_w_en = 0.
  - RAM contents are don't-care after reset; correctness relies only on the pointers.
  - A reset mid-stream discards all stored words. The cycle after reset is released, the FIFO is empty and accepts a push.
- Push:
  - push = wr_valid & wr_ready, where wr_ready = ~full.
  - ram_w_en = push, ram_w_addr = wptr[ADDR_WIDTH-1:0], ram_w_data = wr_data; all combinational.
  - wptr increments on the clock edge when push is high.
  - Wrap from 2**ADDR_WIDTH-1 to 0 toggles the wrap bit.
- Pop:
  - rd_valid = ~empty.
  - ram_r_addr = rptr[ADDR_WIDTH-1:0]; rd_data = ram_r_data, so the head word appears combinationally.
  - pop = rd_valid & rd_ready; rptr increments on the clock edge when pop is high.
  - rd_data is undefined while rd_valid = 0.
- Latency:
  - A word pushed at edge N is visible on rd_data, with rd_valid = 1, in the cycle after edge N (one-cycle fall-through).
  - With the FIFO empty, a word is never presented in the same cycle it is pushed.
- Count is a registered value:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - full, empty and afull are decoded from the registered count or pointers; there is no combinational path from wr_valid or rd_ready to them.
- Simultaneous events:
  - Full plus rd_ready: wr_ready stays 0 that cycle, so push is blocked; the pop completes and wr_ready rises next cycle.
  - Empty plus wr_valid: the push completes and no pop occurs.
  - Push and pop in the same cycle on a partly filled FIFO: both complete and the pointers are never equal at any point.
- Handshake rules:
  - wr_valid and rd_ready are never gated by the block.
  - rd_valid never drops without a pop or a reset.
  - rd_data stays stable while rd_valid & ~rd_ready.

Optional Feature:
- Macro: FIFO_STREAM_ERR_EN.
- When defined:
  - Adds outputs ovf and udf, each 1 bit, sticky, cleared only by reset.
  - ovf sets on the edge after a cycle with wr_valid & full.
  - udf sets on the edge after a cycle with rd_ready & empty.
  - Neither flag affects the data path.
- When not defined:
  - The ports and logic are absent.
  - Attempted overflow or underflow is silently ignored, with no pointer change, as above.

Test Plan:
- Reset low for 2 cycles, then released -> count = 0, empty = 1, wr_ready = 1, rd_valid = 0, ram_w_en = 0.
- Push 8 words 0x1..0x8 with rd_ready = 0 -> count 1..8, afull rises when count reaches 6, full = 1 and wr_ready = 0 after the 8th push; a 9th wr_valid causes no write (ovf = 1 with FIFO_STREAM_ERR_EN).
- From full, pop all words with rd_ready = 1 -> rd_data = 0x1..0x8 in order, empty = 1 after 8 pops, and rd_ready on the empty FIFO sets udf.
- Continuous push and pop for 20 cycles at count = 3 -> count stays 3, data stays in order across pointer wrap (addresses 7 -> 0), no lost or duplicated word.
- Full plus simultaneous wr_valid and rd_ready -> this cycle: only the pop happens. Next cycle: count = 7 and wr_ready = 1. Then push 0xAA -> 0xAA is read out last.
- Reset asserted with count = 5 -> the next cycle empty = 1 and rd_valid = 0; then push 0x55 -> rd_data = 0x55 after one cycle.
